// File: rtl/wc_rr_sched.sv
// wc_rr_sched: round-robin arbiter in front of a shared wide-to-narrow
// fragmentation path. One requester is granted from IDLE, its IWIDTH word is
// captured, then streamed out as AMOUNT fragments of OWIDTH bits, LSB first,
// each tagged with the owning requester index.
module wc_rr_sched #(
  parameter  int NREQ   = 4,
  parameter  int IWIDTH = 288,
  parameter  int OWIDTH = 36,
  localparam int AMOUNT = IWIDTH / OWIDTH,
  localparam int SW     = $clog2(NREQ),
  localparam int CW     = $clog2(AMOUNT)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   frag_valid,
  input  logic                   frag_ready,
  output logic [OWIDTH-1:0]      frag_data,
  output logic [SW-1:0]          frag_src,
  output logic                   frag_first,
  output logic                   frag_last,
  output logic                   busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(AMOUNT - 1);

  state_t              state_q, state_d;
  logic [IWIDTH-1:0]   buf_q, buf_d;
  logic [SW-1:0]       src_q, src_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       ptr_q, ptr_d;

  logic                grant_found;
  logic [SW-1:0]       grant_idx;

  // Rotating-priority search: first valid requester starting at ptr_q.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!grant_found && req_valid[(int'(ptr_q) + off) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = SW'((int'(ptr_q) + off) % NREQ);
      end
    end
  end

  // Next-state, capture and handshake logic. req_ready is also gated by
  // resetn so no requester believes its word was taken while reset is held.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (resetn && grant_found) begin
          req_ready[grant_idx] = 1'b1;
          buf_d   = req_data[int'(grant_idx)*IWIDTH +: IWIDTH];
          src_d   = grant_idx;
          cnt_d   = '0;
          ptr_d   = SW'((int'(grant_idx) + 1) % NREQ);
          state_d = SEND;
        end
      end
      SEND: begin
        if (frag_ready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fragment outputs depend only on registered state, never on frag_ready.
  always_comb begin
    frag_valid = (state_q == SEND);
    busy       = (state_q == SEND);
    frag_src   = src_q;
    frag_data  = '0;
    frag_first = 1'b0;
    frag_last  = 1'b0;
    if (state_q == SEND) begin
      frag_data  = buf_q[int'(cnt_q)*OWIDTH +: OWIDTH];
      frag_first = (cnt_q == '0);
      frag_last  = (cnt_q == LAST_IDX);
    end
  end

  // State registers; asynchronous reset aborts any word in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      buf_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
